clark_share_sched: RTL and testbench

- Time-multiplexes one clark_transform instance between NCH phase-current requesters, e.g. several motor channels or ADC sample streams.
- Each requester offers an (a,b,c) triplet with a valid/ready handshake.
- The block round-robin arbitrates, drives the shared transform, tracks in-flight channel tags through its fixed latency, and returns tagged (alpha,beta,gamma) results through a credit-protected output FIFO with valid/ready.

---
 rtl/clark_share_sched.sv | 144 ++++++++++++++
 tb/tb_clark_share_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clark_share_sched.sv
// Round-robin sharing of one clark_transform between NCH requesters with a credit-protected result FIFO.
// Define CLARK_SHARE_STRICT_PRI_EN for fixed priority (lowest channel index wins).
module clark_share_sched #(
  parameter int NCH   = 2,
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  localparam int CH_W = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           req_valid,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH*16-1:0]        req_a,
  input  logic [NCH*16-1:0]        req_b,
  input  logic [NCH*16-1:0]        req_c,
  output logic signed [15:0]       ct_a,
  output logic signed [15:0]       ct_b,
  output logic signed [15:0]       ct_c,
  input  logic signed [15:0]       ct_alpha,
  input  logic signed [15:0]       ct_beta,
  input  logic signed [15:0]       ct_gamma,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CH_W-1:0]          res_ch,
  output logic signed [15:0]       res_alpha,
  output logic signed [15:0]       res_beta,
  output logic signed [15:0]       res_gamma
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  logic [CH_W-1:0]   ptr_q, ptr_d, grant_ch;
  logic              grant_vld, issue_ok, push, pop;
  logic [CNT_W-1:0]  inflight_q, inflight_d, occ_q, occ_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LAT:0]      tag_vld_q;
  logic [CH_W-1:0]   tag_ch_q [LAT+1];
  logic [CH_W-1:0]   mem_ch_q [DEPTH];
  logic signed [15:0] mem_al_q [DEPTH];
  logic signed [15:0] mem_be_q [DEPTH];
  logic signed [15:0] mem_ga_q [DEPTH];
  logic signed [15:0] ct_a_q, ct_b_q, ct_c_q;

  // Credits cover both in-flight transforms and buffered results, so the FIFO can never overflow.
  assign issue_ok = ({1'b0, inflight_q} + {1'b0, occ_q}) < (CNT_W+1)'(DEPTH);

  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    req_ready = '0;
    if (rst_n && issue_ok) begin
      for (int i = 0; i < NCH; i++) begin
        j = int'(ptr_q) + i;
        if (j >= NCH) j = j - NCH;
        if (!grant_vld && req_valid[j]) begin
          grant_vld = 1'b1;
          grant_ch  = CH_W'(j);
        end
      end
      req_ready[grant_ch] = grant_vld;
    end
  end

  always_comb begin
`ifdef CLARK_SHARE_STRICT_PRI_EN
    ptr_d = '0;
`else
    ptr_d = ptr_q;
    if (grant_vld)
      ptr_d = (grant_ch == CH_W'(NCH-1)) ? '0 : grant_ch + CH_W'(1);
`endif
  end

  assign push      = tag_vld_q[LAT];
  assign res_valid = (occ_q != '0);
  assign pop       = res_valid && res_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (grant_vld && !push)      inflight_d = inflight_q + CNT_W'(1);
    else if (!grant_vld && push) inflight_d = inflight_q - CNT_W'(1);
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + CNT_W'(1);
    else if (!push && pop) occ_d = occ_q - CNT_W'(1);
    wr_d = wr_q;
    if (push) wr_d = (wr_q == PTR_W'(DEPTH-1)) ? '0 : wr_q + PTR_W'(1);
    rd_d = rd_q;
    if (pop)  rd_d = (rd_q == PTR_W'(DEPTH-1)) ? '0 : rd_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      tag_vld_q  <= '0;
      ct_a_q     <= '0;
      ct_b_q     <= '0;
      ct_c_q     <= '0;
      for (int i = 0; i <= LAT; i++) tag_ch_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ch_q[i] <= '0;
        mem_al_q[i] <= '0;
        mem_be_q[i] <= '0;
        mem_ga_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      if (grant_vld) begin
        ct_a_q <= req_a[grant_ch*16 +: 16];
        ct_b_q <= req_b[grant_ch*16 +: 16];
        ct_c_q <= req_c[grant_ch*16 +: 16];
      end
      // Tag stage LAT lines up with the transform output for the triplet issued LAT+1 edges earlier.
      tag_vld_q   <= {tag_vld_q[LAT-1:0], grant_vld};
      tag_ch_q[0] <= grant_ch;
      for (int i = 1; i <= LAT; i++) tag_ch_q[i] <= tag_ch_q[i-1];
      if (push) begin
        mem_ch_q[wr_q] <= tag_ch_q[LAT];
        mem_al_q[wr_q] <= ct_alpha;
        mem_be_q[wr_q] <= ct_beta;
        mem_ga_q[wr_q] <= ct_gamma;
      end
    end
  end

  assign ct_a      = ct_a_q;
  assign ct_b      = ct_b_q;
  assign ct_c      = ct_c_q;
  assign res_ch    = mem_ch_q[rd_q];
  assign res_alpha = mem_al_q[rd_q];
  assign res_beta  = mem_be_q[rd_q];
  assign res_gamma = mem_ga_q[rd_q];

endmodule

// File: tb/tb_clark_share_sched.sv
// Scoreboard bench for clark_share_sched with a one-stage integer Clark model as the shared transform.
module tb_clark_share_sched;
  localparam int NCH = 2;
  localparam int LAT = 1;
  localparam int DEPTH = 4;
  localparam int CH_W = 1;

  logic clk, rst_n;
  logic [NCH-1:0] req_valid, req_ready;
  logic [NCH*16-1:0] req_a, req_b, req_c;
  logic signed [15:0] ct_a, ct_b, ct_c, ct_alpha, ct_beta, ct_gamma;
  logic res_valid, res_ready;
  logic [CH_W-1:0] res_ch;
  logic signed [15:0] res_alpha, res_beta, res_gamma;

  clark_share_sched #(.NCH(NCH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .ct_a(ct_a), .ct_b(ct_b), .ct_c(ct_c),
    .ct_alpha(ct_alpha), .ct_beta(ct_beta), .ct_gamma(ct_gamma),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_alpha(res_alpha), .res_beta(res_beta), .res_gamma(res_gamma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] clark(input logic signed [15:0] a, input logic signed [15:0] b,
                                        input logic signed [15:0] c);
    int al, be, ga;
    al = (2 * int'(a) - int'(b) - int'(c)) / 3;
    be = ((int'(b) - int'(c)) * 18919) >>> 15;
    ga = (int'(a) + int'(b) + int'(c)) / 3;
    return {al[15:0], be[15:0], ga[15:0]};
  endfunction

  always @(posedge clk) {ct_alpha, ct_beta, ct_gamma} <= clark(ct_a, ct_b, ct_c);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [47:0]     d;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_chk = 0, n_pass = 0, n_acc = 0, n_pop = 0;
  logic hold_pend = 1'b0;
  logic [48:0] hold_val;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hold_pend = 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          e.ch = CH_W'(k);
          e.d  = clark(req_a[k*16 +: 16], req_b[k*16 +: 16], req_c[k*16 +: 16]);
          sb.push_back(e);
          grants.push_back(k);
          n_acc++;
        end
      end
      if (dut.tag_vld_q[LAT])
        check_eq("fifo_ovf", 64'((dut.occ_q < DEPTH) || (res_valid && res_ready)), 64'(1));
      if (hold_pend)
        check_eq("head_hold", 64'({res_ch, res_alpha, res_beta, res_gamma}), 64'(hold_val));
      hold_pend = res_valid && !res_ready;
      hold_val  = {res_ch, res_alpha, res_beta, res_gamma};
      if (res_valid && res_ready) begin
        n_pop++;
        if (sb.size() == 0) check_eq("sb_underflow", 64'(0), 64'(1));
        else begin
          e = sb.pop_front();
          check_eq("res_ch", 64'(res_ch), 64'(e.ch));
          check_eq("res_data", 64'({res_alpha, res_beta, res_gamma}), 64'(e.d));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_trip(input int k, input int a, input int b, input int c);
    req_a[k*16 +: 16] = 16'(a);
    req_b[k*16 +: 16] = 16'(b);
    req_c[k*16 +: 16] = 16'(c);
  endtask

  task automatic rand_trips();
    for (int k = 0; k < NCH; k++) set_trip(k, int'($urandom), int'($urandom), int'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    #2;
    req_valid = 2'b11;
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'(0));
    check_eq("rst_ct", 64'({ct_a, ct_b, ct_c}), 64'(0));
    check_eq("rst_res_valid", 64'(res_valid), 64'(0));
    check_eq("rst_res", 64'({res_ch, res_alpha, res_beta, res_gamma}), 64'(0));
    req_valid = '0;
    tick(3);
    rst_n = 1'b1;

    // single request, ch0
    tick();
    set_trip(0, 32767, 0, -32767);
    req_valid = 2'b01; res_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    @(negedge clk);
    check_eq("t1_ct_a", 64'(ct_a), 64'(16'sd32767));
    check_eq("t1_ct_c", 64'(ct_c), 64'(16'(-32767)));
    check_eq("t1_valid_e1", 64'(res_valid), 64'(0));
    tick();
    @(negedge clk);
    check_eq("t1_valid_e2", 64'(res_valid), 64'(0));
    tick();
    @(negedge clk);
    check_eq("t1_valid_e3", 64'(res_valid), 64'(1));
    check_eq("t1_ch", 64'(res_ch), 64'(0));
    check_eq("t1_alpha", 64'(res_alpha), 64'(16'sd32767));

    // arbitration with both channels requesting
    tick(4);
    set_trip(0, -32767, 32767, 0);
    set_trip(1, 0, 32767, -32767);
    grants.delete();
    req_valid = 2'b11;
    tick(8);
    check_eq("arb_count", 64'(grants.size()), 64'(8));
`ifdef CLARK_SHARE_STRICT_PRI_EN
    for (int i = 0; i < grants.size(); i++) check_eq("strict_ch0", 64'(grants[i]), 64'(0));
    grants.delete();
    req_valid = 2'b10;
    tick(2);
    check_eq("strict_ch1_after_drop", 64'(grants.size() > 0 ? grants[0] : -1), 64'(1));
`else
    if (grants.size() > 0) check_eq("rr_first", 64'(grants[0]), 64'(1));
    for (int i = 1; i < grants.size(); i++) check_eq("rr_alt", 64'(grants[i]), 64'(grants[0] ^ (i & 1)));
`endif
    req_valid = '0;

    // credit backpressure
    tick(8);
    check_eq("drain1", 64'(sb.size()), 64'(0));
    res_ready = 1'b0; n_acc = 0;
    rand_trips();
    req_valid = 2'b01;
    tick(10);
    check_eq("credit_accepts", 64'(n_acc), 64'(DEPTH));
    @(negedge clk);
    check_eq("credit_stall", 64'(req_ready), 64'(0));
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("credit_no_reuse", 64'(req_ready), 64'(0));
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    check_eq("credit_regain", 64'(req_ready), 64'(2'b01));
    tick(5);
    check_eq("credit_accepts2", 64'(n_acc), 64'(DEPTH + 1));
    req_valid = '0; res_ready = 1'b1;
    tick(10);
    check_eq("drain2", 64'(sb.size()), 64'(0));

    // sustained throughput
    n_acc = 0; n_pop = 0;
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      rand_trips();
      tick();
    end
    req_valid = '0;
    tick(6);
    check_eq("tput_acc", 64'(n_acc), 64'(20));
    check_eq("tput_pop", 64'(n_pop), 64'(20));

    // random valid/ready mix
    for (int i = 0; i < 60; i++) begin
      rand_trips();
      req_valid = 2'($urandom);
      res_ready = 1'($urandom);
      tick();
    end
    req_valid = '0; res_ready = 1'b1;
    tick(12);
    check_eq("drain3", 64'(sb.size()), 64'(0));

    // asynchronous reset while a result is in flight
    set_trip(0, 1234, -555, 777);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    #2;
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ct", 64'({ct_a, ct_b, ct_c}), 64'(0));
    check_eq("arst_valid", 64'(res_valid), 64'(0));
    check_eq("arst_ready", 64'(req_ready), 64'(0));
    check_eq("arst_res", 64'({res_ch, res_alpha, res_beta, res_gamma}), 64'(0));
    tick(2);
    req_valid = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("arst_no_pulse", 64'(res_valid), 64'(0));
    end
    check_eq("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
